conv_frame_host: RTL and testbench

- Host-side counterpart of the 8x8 / 3x3 convolution engine's frame interface.
- Holds one input image in a local buffer and streams it to the engine as a start pulse plus 64 raster-ordered pixels.
- Collects the 36 raster-ordered 16-bit results the engine returns, stores them for random-access readout and flags completion or protocol errors.
- Sits between the control/RAM side and the convolution engine.

---
 rtl/conv_frame_host_if.sv | 30 +++
 rtl/conv_frame_host.sv | 149 ++++++++++++++
 tb/tb_conv_frame_host.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_frame_host_if.sv
// Engine-side frame link: host streams pixels out, engine streams results back.
// Latency: none, wires only.
// Backpressure: none; both directions are free-running start-pulse/valid streams.
//   conv_in_st  host->engine  one-cycle frame start
//   conv_din    host->engine  raster pixel stream
//   conv_dout   engine->host  result word
//   conv_out_st engine->host  result valid
interface conv_frame_host_if #(
    parameter int PIX_W = 8,
    parameter int RES_W = 16
);
    logic             conv_in_st;
    logic [PIX_W-1:0] conv_din;
    logic [RES_W-1:0] conv_dout;
    logic             conv_out_st;

    modport master (
        output conv_in_st,
        output conv_din,
        input  conv_dout,
        input  conv_out_st
    );

    modport slave (
        input  conv_in_st,
        input  conv_din,
        output conv_dout,
        output conv_out_st
    );
endinterface

// File: rtl/conv_frame_host.sv
// Frame host: buffers one image, streams it to the conv engine, collects results.
// Latency: start -> 1st pixel 1 cycle; rd_addr -> rd_data 1 cycle.
// Backpressure: none; a gap in the result stream or a missing start is an error.
//   clk, rst_n              clock, async active-low reset
//   start_i/busy_o/done_o/err_o  transaction control and status
//   ld_we_i/ld_addr_i/ld_data_i  image buffer write port (IDLE only)
//   rd_addr_i/rd_data_o          result buffer read port (any state)
//   eng                          engine link (master side)
module conv_frame_host #(
    parameter int IMG_W   = 8,
    parameter int K       = 3,
    parameter int PIX_W   = 8,
    parameter int RES_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              err_o,
    input  logic                              ld_we_i,
    input  logic [$clog2(IMG_W*IMG_W)-1:0]    ld_addr_i,
    input  logic [PIX_W-1:0]                  ld_data_i,
    input  logic [$clog2(IMG_W*IMG_W)-1:0]    rd_addr_i,
    output logic [RES_W-1:0]                  rd_data_o,
    conv_frame_host_if.master                 eng
);
    localparam int NPIX  = IMG_W * IMG_W;
    localparam int OUT_W = IMG_W - K + 1;
    localparam int NRES  = OUT_W * OUT_W;
    localparam int AW    = $clog2(NPIX);
    localparam int CW    = $clog2(NPIX + 1);     // send counter reaches NPIX
    localparam int RW    = $clog2(NRES);
    localparam int WW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, FIN} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [RW-1:0]    idx_q, idx_d;
    logic             err_q, err_d;
    logic [RES_W-1:0] rd_data_q;

    logic [PIX_W-1:0] img [NPIX];
    logic [RES_W-1:0] res [NRES];

    logic             img_we;
    logic             res_we;
    logic [RW-1:0]    res_waddr;
    logic [AW-1:0]    snd_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wcnt_d    = wcnt_q;
        idx_d     = idx_q;
        err_d     = err_q;
        res_we    = 1'b0;
        res_waddr = idx_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SEND;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            SEND: begin
                // cnt 0 is the start-pulse cycle, cnt 1..NPIX carry pixels 0..NPIX-1
                if (cnt_q == CW'(NPIX)) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT: begin
                // a result arriving on the last allowed cycle still wins over timeout
                if (eng.conv_out_st) begin
                    res_we    = 1'b1;
                    res_waddr = '0;
                    idx_d     = RW'(1);
                    state_d   = RECV;
                end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            RECV: begin
                if (eng.conv_out_st) begin
                    res_we = 1'b1;
                    if (idx_q == RW'(NRES - 1)) begin
                        state_d = FIN;
                    end else begin
                        idx_d = idx_q + RW'(1);
                    end
                end else begin
                    err_d   = 1'b1;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            wcnt_q    <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wcnt_q    <= wcnt_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            rd_data_q <= (int'(rd_addr_i) < NRES) ? res[RW'(rd_addr_i)] : '0;
        end
    end

    // Buffers survive reset; only the control path is cleared.
    assign img_we = (state_q == IDLE) && ld_we_i;

    always_ff @(posedge clk) begin
        if (img_we) begin
            img[ld_addr_i] <= ld_data_i;
        end
        if (res_we) begin
            res[res_waddr] <= eng.conv_dout;
        end
    end

    assign snd_idx        = AW'(cnt_q - CW'(1));
    assign eng.conv_in_st = (state_q == SEND) && (cnt_q == '0);
    assign eng.conv_din   = ((state_q == SEND) && (cnt_q != '0)) ? img[snd_idx] : '0;

    assign busy_o    = (state_q != IDLE);
    assign done_o    = (state_q == FIN);
    assign err_o     = err_q;
    assign rd_data_o = rd_data_q;
endmodule

// File: tb/tb_conv_frame_host.sv
// Bench for conv_frame_host with a behavioural convolution engine on the link.
// Latency: n/a.
// Backpressure: n/a.
module tb_conv_frame_host;
    localparam int TO = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        ld_we = 1'b0;
    logic [5:0]  ld_addr = '0;
    logic [7:0]  ld_data = '0;
    logic [5:0]  rd_addr = '0;
    logic        busy, done, err;
    logic [15:0] rd_data;

    conv_frame_host_if #(.PIX_W(8), .RES_W(16)) eng ();

    conv_frame_host #(.IMG_W(8), .K(3), .PIX_W(8), .RES_W(16), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .busy_o(busy), .done_o(done),
        .err_o(err), .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .eng(eng)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- engine model ----------------
    int          eng_mode = 0;          // 0: real 3x3 convolution, 1: base+n sequence
    logic [15:0] eng_base = '0;
    int          eng_nwords = 36;
    bit          eng_spur = 1'b0;       // inject a stray result-valid during streaming
    logic [7:0]  cap [64];
    logic [7:0]  cap_post;
    int          cap_inst;
    int          kern [9] = '{8, 16, 8, 16, 32, 16, 8, 16, 8};
    logic [7:0]  exp_img [64];

    function automatic logic [15:0] eng_word(input int n);
        int s;
        if (eng_mode == 1) return eng_base + 16'(n);
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += kern[i*3+j] * int'(cap[((n/6)+i)*8 + (n%6) + j]);
        return 16'(s);
    endfunction

    initial begin : engine
        bit abort;
        eng.conv_out_st = 1'b0;
        eng.conv_dout   = '0;
        forever begin
            @(negedge clk);
            if (rst_n && eng.conv_in_st) begin
                abort    = 1'b0;
                cap_inst = 0;
                for (int k = 0; k < 64; k++) begin
                    @(negedge clk);
                    eng.conv_out_st = 1'b0;
                    eng.conv_dout   = '0;
                    if (!rst_n) begin
                        abort = 1'b1;
                        break;
                    end
                    cap[k] = eng.conv_din;
                    if (eng.conv_in_st) cap_inst++;
                    if (eng_spur && k == 5) begin
                        eng.conv_out_st = 1'b1;
                        eng.conv_dout   = 16'hDEAD;
                    end
                end
                if (!abort) begin
                    @(negedge clk);
                    cap_post = eng.conv_din;
                    @(negedge clk);
                    @(negedge clk);
                    for (int n = 0; n < eng_nwords; n++) begin
                        eng.conv_out_st = 1'b1;
                        eng.conv_dout   = eng_word(n);
                        @(negedge clk);
                    end
                    eng.conv_out_st = 1'b0;
                    eng.conv_dout   = '0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    typedef struct {
        logic [5:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;
    rd_vec_t vec[$];

    function automatic int stream_bad();
        int b = 0;
        for (int k = 0; k < 64; k++) if (cap[k] !== exp_img[k]) b++;
        return b;
    endfunction

    task automatic load_img(input int ramp);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ld_we   = 1'b1;
            ld_addr = 6'(i);
            ld_data = ramp ? 8'(i) : 8'd16;
            exp_img[i] = ld_data;
        end
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic run_frame(input int inj_idx, output int done_idx, output int inst_first,
                             output int inst_cnt, output logic err_first, output logic err_done);
        done_idx = -1; inst_first = -1; inst_cnt = 0; err_first = 1'b0; err_done = 1'b0;
        start = 1'b1;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            start = 1'b0;
            ld_we = 1'b0;
            if (i == inj_idx) begin
                start = 1'b1; ld_we = 1'b1; ld_addr = 6'd10; ld_data = 8'hAA;
            end
            if (i == 1) err_first = err;
            if (eng.conv_in_st) begin
                inst_cnt++;
                if (inst_first < 0) inst_first = i;
            end
            if (done) begin
                done_idx = i;
                err_done = err;
                break;
            end
        end
        @(negedge clk);
        check("done_one_cycle_busy_low", {30'd0, done, busy}, 32'd0);
    endtask

    task automatic read_table(input string nm);
        for (int j = 0; j < vec.size(); j++) begin
            rd_addr = vec[j].addr;
            @(negedge clk);
            check($sformatf("%s_rd[%0d]", nm, vec[j].addr), rd_data, vec[j].exp);
        end
        vec.delete();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin : main
        int dix, ifirst, icnt, cnt;
        logic efirst, edone;

        // reset state
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_in_st", eng.conv_in_st, 0);
        check("rst_din", eng.conv_din, 0);
        check("rst_rd_data", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: constant image through the convolution model
        eng_mode = 0; eng_nwords = 36; eng_spur = 0;
        load_img(0);
        run_frame(0, dix, ifirst, icnt, efirst, edone);
        check("t1_done_idx", dix, 104);
        check("t1_in_st_first", ifirst, 1);
        check("t1_in_st_cnt", icnt, 1);
        check("t1_err", edone, 0);
        check("t1_stream", stream_bad(), 0);
        check("t1_din_after", cap_post, 0);
        check("t1_in_st_in_stream", cap_inst, 0);
        for (int n = 0; n < 36; n++) vec.push_back('{6'(n), 16'd2048});
        read_table("t1");

        // 2: ramp image, last pixel written together with start
        eng_mode = 1; eng_base = 16'h1000; eng_nwords = 36;
        for (int i = 0; i < 63; i++) begin
            @(negedge clk);
            ld_we = 1'b1; ld_addr = 6'(i); ld_data = 8'(i); exp_img[i] = 8'(i);
        end
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 6'd63; ld_data = 8'd63; exp_img[63] = 8'd63;
        run_frame(0, dix, ifirst, icnt, efirst, edone);
        check("t2_done_idx", dix, 104);
        check("t2_err", edone, 0);
        check("t2_stream", stream_bad(), 0);
        for (int n = 0; n < 36; n++) vec.push_back('{6'(n), 16'h1000 + 16'(n)});
        vec.push_back('{6'd40, 16'd0});
        vec.push_back('{6'd63, 16'd0});
        read_table("t2");
        rd_addr = 6'd4;
        @(negedge clk);
        rd_addr = 6'd5;
        #1;
        check("t2_rd_latency_old", rd_data, 16'h1004);
        @(negedge clk);
        check("t2_rd_latency_new", rd_data, 16'h1005);

        // 3: engine silent -> timeout
        eng_nwords = 0;
        run_frame(0, dix, ifirst, icnt, efirst, edone);
        check("t3_done_idx", dix, 98);
        check("t3_err", edone, 1);
        @(negedge clk);
        check("t3_err_sticky", err, 1);

        // 4: result stream drops after 20 words
        eng_base = 16'h2000; eng_nwords = 20;
        run_frame(0, dix, ifirst, icnt, efirst, edone);
        check("t4_done_idx", dix, 89);
        check("t4_err", edone, 1);
        for (int n = 0; n < 20; n++) vec.push_back('{6'(n), 16'h2000 + 16'(n)});
        vec.push_back('{6'd20, 16'h1014});
        vec.push_back('{6'd35, 16'h1023});
        read_table("t4");
        eng_base = 16'h1000; eng_nwords = 36;
        run_frame(0, dix, ifirst, icnt, efirst, edone);
        check("t4b_err_cleared", efirst, 0);
        check("t4b_done_idx", dix, 104);
        check("t4b_err", edone, 0);

        // 5: start + ld_we during SEND, stray valid in SEND, extra valids after FIN
        eng_base = 16'h3000; eng_nwords = 38; eng_spur = 1;
        run_frame(12, dix, ifirst, icnt, efirst, edone);
        eng_spur = 0;
        check("t5_done_idx", dix, 104);
        check("t5_in_st_cnt", icnt, 1);
        check("t5_stream", stream_bad(), 0);
        check("t5_pix10", cap[10], 8'd10);
        cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy || eng.conv_in_st) cnt++;
        end
        check("t5_no_queued_start", cnt, 0);
        vec.push_back('{6'd0, 16'h3000});
        vec.push_back('{6'd5, 16'h3005});
        vec.push_back('{6'd35, 16'h3023});
        read_table("t5");

        // 6: reset at pixel 30, then a clean frame
        eng_mode = 0; eng_nwords = 36;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        check("t6_din_pre", eng.conv_din, 8'd30);
        rst_n = 1'b0;
        #1;
        check("t6_in_st_rst", eng.conv_in_st, 0);
        check("t6_din_rst", eng.conv_din, 0);
        check("t6_busy_rst", busy, 0);
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("t6_no_done", cnt, 0);
        check("t6_rd_data_rst", rd_data, 0);
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, dix, ifirst, icnt, efirst, edone);
        check("t6_done_idx", dix, 104);
        check("t6_err", edone, 0);
        check("t6_stream", stream_bad(), 0);
        // symmetric kernel on a ramp: 128 * centre pixel = 128*(8r+c+9)
        for (int n = 0; n < 36; n++)
            vec.push_back('{6'(n), 16'(128 * (8*(n/6) + (n%6) + 9))});
        read_table("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
